mem_lut_encoder: RTL and testbench

- Reverse (encoder) counterpart of the program-1 address decoder LUT: holds the eight 8-bit data-memory targets and, given an 8-bit address, returns the 3-bit index that maps to it.
- Table is writable at runtime so the program can repoint slots.
- The search is a sequential scan, one entry per cycle, with a req/done handshake.
- Sits beside the control unit; its results feed the LUT-index field when the assembler/loader re-encodes addresses.

---
 rtl/lut_pkg.sv | 20 ++
 rtl/lut_regfile.sv | 35 +++
 rtl/mem_lut_encoder.sv | 112 +++++++++++
 tb/tb_mem_lut_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared constants, types and the power-on table contents for the address encoder LUT.
package lut_pkg;

   localparam int DEPTH = 8;
   localparam int DW    = 8;
   localparam int IDX_W = $clog2(DEPTH);

   typedef logic [DW-1:0]    entry_t;
   typedef logic [IDX_W-1:0] idx_t;

   // Entry 0 sits in the least significant byte.
   localparam entry_t [DEPTH-1:0] DEFAULT_TABLE = {
      8'd91, 8'd62, 8'd0, 8'd0, 8'd99, 8'd30, 8'd200, 8'd180
   };

   localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

endpackage

// File: rtl/lut_regfile.sv
// Table storage: one synchronous write port, two combinational read ports.
module lut_regfile
   import lut_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   we,
   input  idx_t   waddr,
   input  entry_t wdata,
   input  idx_t   raddr_a,
   output entry_t rdata_a,
   input  idx_t   raddr_b,
   output entry_t rdata_b
);

   entry_t [DEPTH-1:0] mem_q;
   entry_t [DEPTH-1:0] mem_d;

   // Merge the pending write into the next table image.
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // Table register; reset reloads the default address map.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= DEFAULT_TABLE;
      else        mem_q <= mem_d;
   end

   // Reads see the registered contents, so a same-cycle write is not visible yet.
   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/mem_lut_encoder.sv
// Reverse lookup of a data-memory address to its LUT slot by scanning one entry per cycle.
module mem_lut_encoder
   import lut_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             WrEn,
   input  logic [IDX_W-1:0] WrAddr,
   input  logic [DW-1:0]    WrData,
   input  logic [IDX_W-1:0] RdAddr,
   output logic [DW-1:0]    RdData,
   input  logic             SearchReq,
   input  logic [DW-1:0]    SearchKey,
   output logic             SearchBusy,
   output logic             Done,
   output logic             Hit,
   output logic [IDX_W-1:0] Index
);

   state_t state_q, state_d;
   entry_t key_q,   key_d;
   idx_t   cnt_q,   cnt_d;
   logic   done_q,  done_d;
   logic   hit_q,   hit_d;
   idx_t   idx_q,   idx_d;

   entry_t scan_data;
   logic   match;

   lut_regfile u_regfile (
      .clk     (Clk),
      .rst_n   (Reset),
      .we      (WrEn),
      .waddr   (WrAddr),
      .wdata   (WrData),
      .raddr_a (RdAddr),
      .rdata_a (RdData),
      .raddr_b (cnt_q),
      .rdata_b (scan_data)
   );

   assign match = (scan_data == key_q);

   // State and datapath registers; reset aborts any scan in flight.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hit_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         idx_q   <= idx_d;
      end
   end

   // Next state: scan ends on the first match or after the last slot.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (SearchReq) state_d = SCAN;
         SCAN:    if (match || (cnt_q == LAST_IDX)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs; results are held until the next accepted request.
   always_comb begin
      key_d  = key_q;
      cnt_d  = cnt_q;
      hit_d  = hit_q;
      idx_d  = idx_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (SearchReq) begin
               key_d = SearchKey;
               cnt_d = '0;
               hit_d = 1'b0;
               idx_d = '0;
            end
         end
         SCAN: begin
            if (match) begin
               hit_d  = 1'b1;
               idx_d  = cnt_q;
               done_d = 1'b1;
            end else if (cnt_q == LAST_IDX) begin
               hit_d  = 1'b0;
               idx_d  = '0;
               done_d = 1'b1;
            end else begin
               cnt_d = idx_t'(cnt_q + idx_t'(1));
            end
         end
         default: ;
      endcase
   end

   assign SearchBusy = (state_q != IDLE);
   assign Done       = done_q;
   assign Hit        = hit_q;
   assign Index      = idx_q;

endmodule

// File: tb/tb_mem_lut_encoder.sv
// Scoreboard bench for mem_lut_encoder: directed searches, writes and a mid-scan reset.
module tb_mem_lut_encoder;

   logic       Clk;
   logic       Reset;
   logic       WrEn;
   logic [2:0] WrAddr;
   logic [7:0] WrData;
   logic [2:0] RdAddr;
   logic [7:0] RdData;
   logic       SearchReq;
   logic [7:0] SearchKey;
   logic       SearchBusy;
   logic       Done;
   logic       Hit;
   logic [2:0] Index;

   mem_lut_encoder dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .WrEn       (WrEn),
      .WrAddr     (WrAddr),
      .WrData     (WrData),
      .RdAddr     (RdAddr),
      .RdData     (RdData),
      .SearchReq  (SearchReq),
      .SearchKey  (SearchKey),
      .SearchBusy (SearchBusy),
      .Done       (Done),
      .Hit        (Hit),
      .Index      (Index)
   );

   typedef struct {
      logic       hit;
      logic [2:0] idx;
      int         done_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin : monitor
      exp_t e;
      if (Done) begin
         if (sb_q.size() == 0) begin
            chk("done_without_request", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            chk("hit", int'(Hit), int'(e.hit));
            chk("index", int'(Index), int'(e.idx));
            chk("done_cycle", cyc, e.done_cyc);
         end
      end
   end

   // Issue one search; optionally re-pulse SearchReq with another key in cycles 1-4,
   // and optionally write a table entry in cycle 1.
   task automatic search(input logic [7:0] key, input logic hit, input int idx,
                         input int lat, input bit junk, input bit wr1,
                         input int wa, input logic [7:0] wd);
      int c;
      @(posedge Clk); #1;
      SearchReq = 1'b1;
      SearchKey = key;
      c = cyc;
      sb_q.push_back('{hit: hit, idx: 3'(idx), done_cyc: c + lat});
      for (int j = 1; j <= lat + 1; j++) begin
         @(posedge Clk); #1;
         SearchReq = junk && (j <= 4);
         if (junk) SearchKey = 8'd200;
         WrEn   = wr1 && (j == 1);
         WrAddr = 3'(wa);
         WrData = wd;
         @(negedge Clk);
         chk($sformatf("busy_key%0d_c%0d", key, j), int'(SearchBusy), (j <= lat) ? 1 : 0);
         if (j == lat + 1) begin
            chk($sformatf("hit_held_key%0d", key), int'(Hit), int'(hit));
            chk($sformatf("index_held_key%0d", key), int'(Index), idx);
         end
      end
      SearchReq = 1'b0;
      WrEn      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      Reset     = 1'b0;
      WrEn      = 1'b0;
      WrAddr    = '0;
      WrData    = '0;
      RdAddr    = '0;
      SearchReq = 1'b0;
      SearchKey = '0;

      repeat (2) @(negedge Clk);
      chk("rst_busy",  int'(SearchBusy), 0);
      chk("rst_done",  int'(Done), 0);
      chk("rst_hit",   int'(Hit), 0);
      chk("rst_index", int'(Index), 0);
      chk("rst_rd0",   int'(RdData), 180);
      RdAddr = 3'd7; #1;
      chk("rst_rd7",   int'(RdData), 91);

      @(posedge Clk); #1;
      Reset = 1'b1;

      // Plain hit, duplicate (lowest index), miss.
      search(8'd30, 1'b1, 2, 4, 1'b0, 1'b0, 0, 8'd0);
      search(8'd0,  1'b1, 4, 6, 1'b0, 1'b0, 0, 8'd0);
      search(8'd17, 1'b0, 0, 9, 1'b0, 1'b0, 0, 8'd0);

      // Repoint slot 6 and find it.
      @(posedge Clk); #1;
      WrEn = 1'b1; WrAddr = 3'd6; WrData = 8'd17;
      @(posedge Clk); #1;
      WrEn = 1'b0; RdAddr = 3'd6; #1;
      chk("rd6_after_write", int'(RdData), 17);
      search(8'd17, 1'b1, 6, 8, 1'b0, 1'b0, 0, 8'd0);

      // Write slot 0 while it is being compared: old value (180) is used, hit at 3.
      search(8'd99, 1'b1, 3, 5, 1'b0, 1'b1, 0, 8'd99);
      RdAddr = 3'd0; #1;
      chk("rd0_after_concurrent_write", int'(RdData), 99);

      // Extra requests with a different key while busy must be ignored.
      search(8'd91, 1'b1, 7, 9, 1'b1, 1'b0, 0, 8'd0);

      // Reset in cycle 3 of a key-91 scan: no Done, outputs cleared, table restored.
      @(posedge Clk); #1;
      SearchReq = 1'b1; SearchKey = 8'd91;
      @(posedge Clk); #1;
      SearchReq = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset  = 1'b0;
      RdAddr = 3'd6; #1;
      chk("abort_busy",  int'(SearchBusy), 0);
      chk("abort_done",  int'(Done), 0);
      chk("abort_hit",   int'(Hit), 0);
      chk("abort_index", int'(Index), 0);
      chk("abort_rd6",   int'(RdData), 62);
      RdAddr = 3'd0; #1;
      chk("abort_rd0",   int'(RdData), 180);
      repeat (2) @(posedge Clk); #1;
      Reset = 1'b1;
      repeat (12) @(negedge Clk);
      chk("abort_idle_busy", int'(SearchBusy), 0);

      // Restored default in slot 6 is found again.
      search(8'd62, 1'b1, 6, 8, 1'b0, 1'b0, 0, 8'd0);

      repeat (3) @(negedge Clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
